// File: rtl/gf180mcu_osu_sc_12t_cell_bist_ctrl.sv
// Exhaustive self-test sequencer for a 4-input library cell: walks all 16 input
// vectors (binary or Gray order), waits a settle window, samples and scores the output.
module gf180mcu_osu_sc_12t_cell_bist_ctrl #(
    parameter logic [15:0] TRUTH  = 16'h01FF,
    parameter int unsigned SETTLE = 2
) (
    input  logic       CLK,
    input  logic       RN,
    input  logic       start,
    input  logic       gray,
    input  logic       abort,
    input  logic       dut_y,
    output logic [3:0] vec,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic [3:0] fail_vec,
    output logic       fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_e;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    function automatic logic [3:0] map_vec(input logic [3:0] idx, input logic use_gray);
        return use_gray ? (idx ^ (idx >> 1)) : idx;
    endfunction

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] cnt_q, cnt_d;
    logic       gray_q, gray_d;
    logic [3:0] vec_q, vec_d;
    logic [4:0] err_q, err_d;
    logic [3:0] fvec_q, fvec_d;
    logic       fvalid_q, fvalid_d;

    logic       mismatch;
    logic [3:0] next_step;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge CLK) begin
        if (!RN) begin
            state_q  <= ST_IDLE;
            step_q   <= '0;
            cnt_q    <= '0;
            gray_q   <= 1'b0;
            vec_q    <= '0;
            err_q    <= '0;
            fvec_q   <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            cnt_q    <= cnt_d;
            gray_q   <= gray_d;
            vec_q    <= vec_d;
            err_q    <= err_d;
            fvec_q   <= fvec_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign mismatch  = (dut_y != TRUTH[vec_q]);
    assign next_step = step_q + 4'd1;

    // NOTE: every signal gets a hold-value default up front so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        cnt_d    = cnt_q;
        gray_d   = gray_q;
        vec_d    = vec_q;
        err_d    = err_q;
        fvec_d   = fvec_q;
        fvalid_d = fvalid_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_SETTLE;
                    gray_d   = gray;
                    step_d   = '0;
                    vec_d    = map_vec(4'd0, gray);
                    cnt_d    = SETTLE_CNT;
                    err_d    = '0;
                    fvec_d   = '0;
                    fvalid_d = 1'b0;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                    vec_d   = '0;
                end else if (cnt_q == 8'd0) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SAMPLE: begin
                if (abort) begin
                    // The pending sample is discarded; earlier results are kept.
                    state_d = ST_IDLE;
                    step_d  = '0;
                    cnt_d   = '0;
                    vec_d   = '0;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 5'd1;
                        if (!fvalid_q) begin
                            fvec_d   = vec_q;
                            fvalid_d = 1'b1;
                        end
                    end
                    if (step_q == 4'd15) begin
                        state_d = ST_DONE;
                        step_d  = '0;
                        vec_d   = '0;
                    end else begin
                        state_d = ST_SETTLE;
                        step_d  = next_step;
                        vec_d   = map_vec(next_step, gray_q);
                        cnt_d   = SETTLE_CNT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);
        done       = (state_q == ST_DONE);
        pass       = done && (err_q == 5'd0);
        vec        = vec_q;
        err_cnt    = err_q;
        fail_vec   = fvec_q;
        fail_valid = fvalid_q;
    end

endmodule
